// File: rtl/regfile_reader.sv
// Read side of the 8x8 register bank: two registered read ports with write
// forwarding, plus a valid/ready dump engine that streams a register range.
module regfile_reader #(
  parameter int WIDTH = 8,
  parameter int AW    = 4,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic [WIDTH-1:0] D4,
  input  logic [WIDTH-1:0] D5,
  input  logic [WIDTH-1:0] D6,
  input  logic [WIDTH-1:0] D7,
  input  logic [AW-1:0]    wa3,
  input  logic             we3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW-1:0]    end_addr,
  output logic             busy,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [AW-1:0]    dump_addr,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_done
);

  localparam int NADDR = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    end_q, end_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] rd1_q, rd2_q;

  logic [WIDTH-1:0] bank [NREGS];
  logic [WIDTH-1:0] effVal [NADDR];
  logic [AW-1:0]    clampEnd;
  logic [AW-1:0]    nextAddr;

  assign bank[0] = D0;
  assign bank[1] = D1;
  assign bank[2] = D2;
  assign bank[3] = D3;
  assign bank[4] = D4;
  assign bank[5] = D5;
  assign bank[6] = D6;
  assign bank[7] = D7;

  // Post-write view of every address; unimplemented addresses read as zero
  // and never pick up a forwarded write.
  always_comb begin
    for (int i = 0; i < NADDR; i++) effVal[i] = '0;
    for (int i = 0; i < NREGS; i++)
      effVal[i] = (we3 && wa3 == AW'(i)) ? wd3 : bank[i];
  end

  assign clampEnd = (end_addr > LAST) ? LAST : end_addr;
  assign nextAddr = addr_q + AW'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_addr > clampEnd) begin
            state_d = DONE;
          end else begin
            state_d = STREAM;
            addr_d  = start_addr;
            end_d   = clampEnd;
            data_d  = effVal[start_addr];
            valid_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (dump_ready) begin
          if (addr_q == end_q) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else begin
            addr_d = nextAddr;
            data_d = effVal[nextAddr];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rd1_q   <= effVal[ra1];
      rd2_q   <= effVal[ra2];
    end
  end

  assign rd1        = rd1_q;
  assign rd2        = rd2_q;
  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign busy       = (state_q != IDLE);
  assign dump_done  = (state_q == DONE);

endmodule
